data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 34 +++
 rtl/data_cache_load_align_extend.sv | 33 +++
 rtl/data_cache.sv | 195 +++++++++++++++++++
 tb/tb_data_cache.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared definitions for the data cache: load/store codes, FSM state
// encoding and byte-strobe generation.
package data_cache_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;

    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    // Byte strobes for a store, positioned at the byte offset
    function automatic logic [3:0] store_strobe(input logic [1:0] code,
                                                input logic [1:0] offset);
        logic [3:0] base;
        case (code)
            ST_SB:   base = 4'b0001;
            ST_SH:   base = 4'b0011;
            ST_SW:   base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/data_cache_load_align_extend.sv
// Lane select and sign/zero extension of a cached word for a load.
module load_align_extend
    import data_cache_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  load_code,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and extend it according to the load code
    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
        case (load_code)
            LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {24'd0, byte_sel};
            LD_LH:   data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data = {16'd0, half_sel};
            LD_LW:   data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines. Optional hit/miss statistics are enabled by DATA_CACHE_STATS_EN.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int D_CACHE_LW_WIDTH = 3,
    parameter int D_CACHE_SW_WIDTH = 2,
    parameter int LINE_COUNT       = 16
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [ADDRESS_WIDTH-1:0]    ADDRESS,
    input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD,
    input  logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE,
    input  logic [DATA_WIDTH-1:0]       DATA_CACHE_STORE_DATA,
    output logic [DATA_WIDTH-1:0]       DATA_OUT,
    output logic                        DATA_CACHE_READY,
    output logic                        MISALIGNED,
    output logic                        MEM_REQ,
    output logic                        MEM_WE,
    output logic [ADDRESS_WIDTH-1:0]    MEM_ADDR,
    output logic [DATA_WIDTH-1:0]       MEM_WDATA,
    output logic [3:0]                  MEM_WSTRB,
    input  logic                        MEM_ACK,
    input  logic [DATA_WIDTH-1:0]       MEM_RDATA,
    output logic [31:0]                 HIT_COUNT,
    output logic [31:0]                 MISS_COUNT
);

    localparam int IDX_W = $clog2(LINE_COUNT);
    localparam int TAG_W = ADDRESS_WIDTH - IDX_W - 2;

    logic [1:0]            state, state_nxt;
    logic                  just_done;
    logic [LINE_COUNT-1:0] valid;
    logic [TAG_W-1:0]      tag_mem  [LINE_COUNT];
    logic [DATA_WIDTH-1:0] data_mem [LINE_COUNT];

    logic [1:0]            offset;
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  st_any, ld_any, ld_half, ld_word, is_load;
    logic                  misalign, hit;
    logic [DATA_WIDTH-1:0] lane_data, store_word;

    logic [DATA_WIDTH-1:0]    data_c, wdata_c;
    logic [ADDRESS_WIDTH-1:0] addr_c;
    logic [3:0]               wstrb_c;
    logic                     ready_c, mis_c, req_c, we_c;

    assign offset  = ADDRESS[1:0];
    assign idx     = ADDRESS[IDX_W+1:2];
    assign tag     = ADDRESS[ADDRESS_WIDTH-1:IDX_W+2];
    assign st_any  = (DATA_CACHE_STORE != ST_NONE);
    assign ld_any  = (DATA_CACHE_LOAD >= LD_LB) && (DATA_CACHE_LOAD <= LD_LHU);
    assign ld_half = (DATA_CACHE_LOAD == LD_LH) || (DATA_CACHE_LOAD == LD_LHU);
    assign ld_word = (DATA_CACHE_LOAD == LD_LW);
    assign is_load = ld_any && !st_any;
    assign hit     = valid[idx] && (tag_mem[idx] == tag);

    // A store takes priority, so only its alignment matters when both are set
    assign misalign = st_any
        ? (((DATA_CACHE_STORE == ST_SH) && offset[0]) ||
           ((DATA_CACHE_STORE == ST_SW) && (offset != 2'd0)))
        : ((ld_half && offset[0]) || (ld_word && (offset != 2'd0)));

    load_align_extend u_align (
        .word      (data_mem[idx]),
        .offset    (offset),
        .load_code (DATA_CACHE_LOAD),
        .data      (lane_data)
    );

    // Right-aligned store data masked to its size, then moved to its lanes
    always_comb begin
        case (DATA_CACHE_STORE)
            ST_SB:   store_word = {24'd0, DATA_CACHE_STORE_DATA[7:0]};
            ST_SH:   store_word = {16'd0, DATA_CACHE_STORE_DATA[15:0]};
            default: store_word = DATA_CACHE_STORE_DATA;
        endcase
        store_word = store_word << {offset, 3'b000};
    end

    // Next-state and output decode; just_done marks the cycle the stalled
    // instruction completes, so a held store is not reissued
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b1;
        data_c    = '0;
        mis_c     = 1'b0;
        req_c     = 1'b0;
        we_c      = 1'b0;
        addr_c    = '0;
        wstrb_c   = 4'b0000;
        wdata_c   = '0;
        case (state)
            S_IDLE: begin
                if (misalign) begin
                    mis_c = 1'b1;
                end else if (st_any) begin
                    if (!just_done) begin
                        ready_c   = 1'b0;
                        state_nxt = S_WRITE;
                    end
                end else if (is_load) begin
                    if (hit) begin
                        data_c = lane_data;
                    end else begin
                        ready_c   = 1'b0;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                ready_c = 1'b0;
                req_c   = 1'b1;
                addr_c  = {ADDRESS[ADDRESS_WIDTH-1:2], 2'b00};
                if (MEM_ACK) state_nxt = S_IDLE;
            end
            S_WRITE: begin
                ready_c = 1'b0;
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = {ADDRESS[ADDRESS_WIDTH-1:2], 2'b00};
                wstrb_c = store_strobe(DATA_CACHE_STORE, offset);
                wdata_c = store_word;
                if (MEM_ACK) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reset overrides the combinational outputs while RST_N is held low
    assign DATA_OUT         = RST_N ? data_c  : '0;
    assign DATA_CACHE_READY = RST_N ? ready_c : 1'b1;
    assign MISALIGNED       = RST_N ? mis_c   : 1'b0;
    assign MEM_REQ          = RST_N ? req_c   : 1'b0;
    assign MEM_WE           = RST_N ? we_c    : 1'b0;
    assign MEM_WSTRB        = RST_N ? wstrb_c : 4'b0000;
    assign MEM_ADDR         = addr_c;
    assign MEM_WDATA        = wdata_c;

    // FSM state, completion marker and line valid bits
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            just_done <= 1'b0;
            valid     <= '0;
        end else begin
            state     <= state_nxt;
            just_done <= (state != S_IDLE) && MEM_ACK;
            if ((state == S_FETCH) && MEM_ACK) valid[idx] <= 1'b1;
        end
    end

    // Tag/data storage: fill on fetch, byte-merge on a write-through hit
    always_ff @(posedge CLK) begin
        if ((state == S_FETCH) && MEM_ACK) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= MEM_RDATA;
        end else if ((state == S_WRITE) && MEM_ACK && hit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_c[b]) data_mem[idx][8*b +: 8] <= wdata_c[8*b +: 8];
            end
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
    logic        count_hit, count_miss;

    assign count_hit  = (state == S_IDLE) && !misalign && is_load && hit && !just_done;
    assign count_miss = (state == S_IDLE) && !misalign && is_load && !hit;

    // Saturating hit/miss statistics
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (count_hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 32'd1;
            if (count_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign HIT_COUNT  = hit_cnt;
    assign MISS_COUNT = miss_cnt;
`else
    assign HIT_COUNT  = '0;
    assign MISS_COUNT = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a small memory model
// and an expected-result queue.
module tb_data_cache;
    import data_cache_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] ADDRESS;
    logic [2:0]  DATA_CACHE_LOAD;
    logic [1:0]  DATA_CACHE_STORE;
    logic [31:0] DATA_CACHE_STORE_DATA;
    logic [31:0] DATA_OUT;
    logic        DATA_CACHE_READY;
    logic        MISALIGNED;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_WSTRB;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic [31:0] HIT_COUNT;
    logic [31:0] MISS_COUNT;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mem [logic [29:0]];

    always #5 CLK = ~CLK;

    data_cache #(
        .ADDRESS_WIDTH    (32),
        .DATA_WIDTH       (32),
        .D_CACHE_LW_WIDTH (3),
        .D_CACHE_SW_WIDTH (2),
        .LINE_COUNT       (16)
    ) dut (
        .CLK                   (CLK),
        .RST_N                 (RST_N),
        .ADDRESS               (ADDRESS),
        .DATA_CACHE_LOAD       (DATA_CACHE_LOAD),
        .DATA_CACHE_STORE      (DATA_CACHE_STORE),
        .DATA_CACHE_STORE_DATA (DATA_CACHE_STORE_DATA),
        .DATA_OUT              (DATA_OUT),
        .DATA_CACHE_READY      (DATA_CACHE_READY),
        .MISALIGNED            (MISALIGNED),
        .MEM_REQ               (MEM_REQ),
        .MEM_WE                (MEM_WE),
        .MEM_ADDR              (MEM_ADDR),
        .MEM_WDATA             (MEM_WDATA),
        .MEM_WSTRB             (MEM_WSTRB),
        .MEM_ACK               (MEM_ACK),
        .MEM_RDATA             (MEM_RDATA),
        .HIT_COUNT             (HIT_COUNT),
        .MISS_COUNT            (MISS_COUNT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stat(input int v);
`ifdef DATA_CACHE_STATS_EN
        return v;
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] code, input logic [31:0] w,
                                             input logic [1:0] off);
        logic [31:0] s;
        s = w >> (off * 8);
        case (code)
            LD_LB:   return {{24{s[7]}}, s[7:0]};
            LD_LBU:  return {24'd0, s[7:0]};
            LD_LH:   return {{16{s[15]}}, s[15:0]};
            LD_LHU:  return {16'd0, s[15:0]};
            LD_LW:   return w;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        ADDRESS               = 32'd0;
        DATA_CACHE_LOAD       = LD_NONE;
        DATA_CACHE_STORE      = ST_NONE;
        DATA_CACHE_STORE_DATA = 32'd0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] code, input logic [31:0] a,
                           input bit miss, input int delay);
        @(negedge CLK);
        ADDRESS = a; DATA_CACHE_LOAD = code; DATA_CACHE_STORE = ST_NONE;
        exp_q.push_back(ref_load(code, mem_word(a), a[1:0]));
        #1;
        if (miss) begin
            chk({tag, " ready_low"}, {31'd0, DATA_CACHE_READY}, 32'd0);
            @(negedge CLK); #1;
            chk({tag, " req"}, {31'd0, MEM_REQ}, 32'd1);
            chk({tag, " we"}, {31'd0, MEM_WE}, 32'd0);
            chk({tag, " addr"}, MEM_ADDR, {a[31:2], 2'b00});
            for (int i = 0; i < delay; i++) begin
                @(negedge CLK); #1;
                chk({tag, " stall_ready"}, {31'd0, DATA_CACHE_READY}, 32'd0);
                chk({tag, " stall_addr"}, MEM_ADDR, {a[31:2], 2'b00});
            end
            MEM_ACK = 1'b1; MEM_RDATA = mem_word(a);
            @(negedge CLK);
            MEM_ACK = 1'b0; MEM_RDATA = 32'd0;
            #1;
        end else begin
            chk({tag, " no_req"}, {31'd0, MEM_REQ}, 32'd0);
        end
        chk({tag, " ready"}, {31'd0, DATA_CACHE_READY}, 32'd1);
        chk({tag, " data"}, DATA_OUT, exp_q.pop_front());
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic do_store(input string tag, input logic [1:0] code, input logic [2:0] ld,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
        logic [31:0] lanes, m, w;
        lanes = d << (a[1:0] * 8);
        m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        @(negedge CLK);
        ADDRESS = a; DATA_CACHE_STORE = code; DATA_CACHE_LOAD = ld; DATA_CACHE_STORE_DATA = d;
        exp_q.push_back({28'd0, strb});
        #1;
        chk({tag, " ready_low"}, {31'd0, DATA_CACHE_READY}, 32'd0);
        @(negedge CLK); #1;
        chk({tag, " req"}, {31'd0, MEM_REQ}, 32'd1);
        chk({tag, " we"}, {31'd0, MEM_WE}, 32'd1);
        chk({tag, " addr"}, MEM_ADDR, {a[31:2], 2'b00});
        chk({tag, " wstrb"}, {28'd0, MEM_WSTRB}, exp_q.pop_front());
        chk({tag, " wdata"}, MEM_WDATA & m, lanes & m);
        w = (mem_word(a) & ~m) | (lanes & m);
        mem[a[31:2]] = w;
        MEM_ACK = 1'b1;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        #1;
        chk({tag, " ready"}, {31'd0, DATA_CACHE_READY}, 32'd1);
        chk({tag, " req_done"}, {31'd0, MEM_REQ}, 32'd0);
        @(negedge CLK);
        idle_inputs();
        #1;
        chk({tag, " no_reissue"}, {31'd0, MEM_REQ}, 32'd0);
    endtask

    task automatic do_mis(input string tag, input logic [2:0] ld, input logic [1:0] st,
                          input logic [31:0] a);
        @(negedge CLK);
        ADDRESS = a; DATA_CACHE_LOAD = ld; DATA_CACHE_STORE = st; DATA_CACHE_STORE_DATA = 32'hA5A5A5A5;
        #1;
        chk({tag, " flag"}, {31'd0, MISALIGNED}, 32'd1);
        chk({tag, " data"}, DATA_OUT, 32'd0);
        chk({tag, " ready"}, {31'd0, DATA_CACHE_READY}, 32'd1);
        chk({tag, " req"}, {31'd0, MEM_REQ}, 32'd0);
        @(negedge CLK);
        idle_inputs();
        #1;
        chk({tag, " flag_clear"}, {31'd0, MISALIGNED}, 32'd0);
        chk({tag, " no_state_change"}, {31'd0, MEM_REQ}, 32'd0);
    endtask

    initial begin
        RST_N = 1'b0; MEM_ACK = 1'b0; MEM_RDATA = 32'd0;
        idle_inputs();
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h104 >> 2] = 32'h12345678;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst ready", {31'd0, DATA_CACHE_READY}, 32'd1);
        chk("rst req", {31'd0, MEM_REQ}, 32'd0);
        chk("rst we", {31'd0, MEM_WE}, 32'd0);
        chk("rst wstrb", {28'd0, MEM_WSTRB}, 32'd0);
        chk("rst misaligned", {31'd0, MISALIGNED}, 32'd0);
        chk("rst data", DATA_OUT, 32'd0);
        chk("rst hits", HIT_COUNT, 32'd0);
        chk("rst misses", MISS_COUNT, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        do_load("lw_miss", LD_LW, 32'h100, 1'b1, 0);
        chk("misses_1", MISS_COUNT, stat(1));
        chk("hits_0", HIT_COUNT, stat(0));
        do_load("lw_hit", LD_LW, 32'h100, 1'b0, 0);
        chk("hits_1", HIT_COUNT, stat(1));
        do_load("lb_103", LD_LB, 32'h103, 1'b0, 0);
        do_load("lbu_103", LD_LBU, 32'h103, 1'b0, 0);
        do_load("lhu_102", LD_LHU, 32'h102, 1'b0, 0);
        do_load("lh_102", LD_LH, 32'h102, 1'b0, 0);
        chk("hits_5", HIT_COUNT, stat(5));

        do_store("sb_101", ST_SB, LD_NONE, 32'h101, 32'h00000055, 4'b0010);
        do_load("lw_after_sb", LD_LW, 32'h100, 1'b0, 0);
        chk("merged_word", mem_word(32'h100), 32'hDEAD55EF);

        do_store("sh_106", ST_SH, LD_NONE, 32'h106, 32'hFFFFABCD, 4'b1100);
        do_load("lw_104_slow", LD_LW, 32'h104, 1'b1, 5);
        do_load("lh_106", LD_LH, 32'h106, 1'b0, 0);
        chk("misses_2", MISS_COUNT, stat(2));
        chk("hits_7", HIT_COUNT, stat(7));

        do_mis("mis_lw_102", LD_LW, ST_NONE, 32'h102);
        do_mis("mis_sh_101", LD_NONE, ST_SH, 32'h101);
        do_mis("mis_lhu_103", LD_LHU, ST_NONE, 32'h103);

        do_store("sw_with_lb", ST_SW, LD_LB, 32'h100, 32'hCAFEF00D, 4'b1111);
        do_load("lb_100", LD_LB, 32'h100, 1'b0, 0);
        chk("hits_8", HIT_COUNT, stat(8));
        chk("misses_still_2", MISS_COUNT, stat(2));

        @(negedge CLK);
        DATA_CACHE_LOAD = 3'd6; ADDRESS = 32'h100;
        #1;
        chk("code6 data", DATA_OUT, 32'd0);
        chk("code6 ready", {31'd0, DATA_CACHE_READY}, 32'd1);
        chk("code6 req", {31'd0, MEM_REQ}, 32'd0);
        @(negedge CLK);
        idle_inputs();

        @(negedge CLK);
        ADDRESS = 32'h200; DATA_CACHE_LOAD = LD_LW;
        @(negedge CLK); #1;
        chk("fetch req", {31'd0, MEM_REQ}, 32'd1);
        RST_N = 1'b0;
        #1;
        chk("rst_fetch req", {31'd0, MEM_REQ}, 32'd0);
        chk("rst_fetch ready", {31'd0, DATA_CACHE_READY}, 32'd1);
        chk("rst_fetch misses", MISS_COUNT, 32'd0);
        idle_inputs();
        @(negedge CLK);
        RST_N = 1'b1;
        MEM_ACK = 1'b1; MEM_RDATA = 32'h11111111;
        @(negedge CLK);
        MEM_ACK = 1'b0; MEM_RDATA = 32'd0;
        #1;
        chk("late_ack req", {31'd0, MEM_REQ}, 32'd0);
        chk("late_ack ready", {31'd0, DATA_CACHE_READY}, 32'd1);
        do_load("lw_after_rst", LD_LW, 32'h100, 1'b1, 0);
        chk("misses_after_rst", MISS_COUNT, stat(1));

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
